// File: rtl/cond_eval_unit_if.sv
// Handshake, flag-write and flush signals between issue logic and cond_eval_unit.
// The master side drives requests and flags; the slave side (the unit) returns decisions.
interface cond_eval_unit_if #(
    parameter int unsigned TAG_W = 5
);
    logic             flags_we;
    logic [3:0]       flags_in;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_cond;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_exec;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       flags_q;

    modport master (
        output flags_we, flags_in, flush, in_valid, in_cond, in_tag, out_ready,
        input  in_ready, out_valid, out_exec, out_tag, flags_q
    );

    modport slave (
        input  flags_we, flags_in, flush, in_valid, in_cond, in_tag, out_ready,
        output in_ready, out_valid, out_exec, out_tag, flags_q
    );
endinterface

// File: rtl/cond_eval_unit.sv
// NZCV status register plus condition evaluator behind a one-entry valid/ready stage.
// FLAG_BYPASS_EN: same-cycle flag writes are forwarded to the evaluator instead of stalling.
module cond_eval_unit #(
    parameter int unsigned TAG_W = 5
) (
    input logic             clk,
    input logic             rst_n,
    cond_eval_unit_if.slave bus
);
    logic [3:0]       r_flags;
    logic             r_out_valid;
    logic             r_out_exec;
    logic [TAG_W-1:0] r_out_tag;

    logic [3:0] w_flags;
    logic       w_stall;
    logic       w_accept;
    logic       w_exec;
    logic       w_n, w_z, w_c, w_v;

`ifdef FLAG_BYPASS_EN
    assign w_flags = bus.flags_we ? bus.flags_in : r_flags;
    assign w_stall = 1'b0;
`else
    // Hold off a colliding request so it is evaluated against the committed flags.
    assign w_flags = r_flags;
    assign w_stall = bus.flags_we & bus.in_valid;
`endif

    assign {w_n, w_z, w_c, w_v} = w_flags;

    assign bus.in_ready  = (!r_out_valid || bus.out_ready) && !w_stall;
    assign w_accept      = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.out_valid = r_out_valid;
    assign bus.out_exec  = r_out_exec;
    assign bus.out_tag   = r_out_tag;
    assign bus.flags_q   = r_flags;

    always_comb begin
        w_exec = 1'b0;
        case (bus.in_cond)
            4'h0:    w_exec = w_z;
            4'h1:    w_exec = !w_z;
            4'h2:    w_exec = w_c;
            4'h3:    w_exec = !w_c;
            4'h4:    w_exec = w_n;
            4'h5:    w_exec = !w_n;
            4'h6:    w_exec = w_v;
            4'h7:    w_exec = !w_v;
            4'h8:    w_exec = w_c && !w_z;
            4'h9:    w_exec = !w_c || w_z;
            4'hA:    w_exec = (w_n == w_v);
            4'hB:    w_exec = (w_n != w_v);
            4'hC:    w_exec = !w_z && (w_n == w_v);
            4'hD:    w_exec = w_z || (w_n != w_v);
            4'hE:    w_exec = 1'b1;
            default: w_exec = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags     <= 4'b0000;
            r_out_valid <= 1'b0;
            r_out_exec  <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            if (bus.flags_we) begin
                r_flags <= bus.flags_in;
            end
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_exec  <= w_exec;
                r_out_tag   <= bus.in_tag;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed self-checking bench for cond_eval_unit (works with or without FLAG_BYPASS_EN).
module tb_cond_eval_unit;
    localparam int unsigned TAG_W = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cond_eval_unit_if #(.TAG_W(TAG_W)) bus ();

    cond_eval_unit #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic [3:0] f);
        bus.flags_we = 1'b1;
        bus.flags_in = f;
        tick();
        bus.flags_we = 1'b0;
    endtask

    logic [15:0] exp_vec;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.flags_we  = 1'b0;
        bus.flags_in  = 4'b0000;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cond   = 4'h0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_out_exec", {31'd0, bus.out_exec}, 32'd0);
        check_eq("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
        check_eq("rst_flags_q", {28'd0, bus.flags_q}, 32'd0);
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Decode sweep, flags Z,C
        write_flags(4'b0110);
        check_eq("sweep_flags_q", {28'd0, bus.flags_q}, 32'h6);
        exp_vec = 16'b0110_0110_1010_0101;
        for (int c = 0; c < 16; c++) begin
            bus.in_valid = 1'b1;
            bus.in_cond  = 4'(c);
            bus.in_tag   = 5'(c);
            #1;
            check_eq($sformatf("sweep_in_ready_%0d", c), {31'd0, bus.in_ready}, 32'd1);
            tick();
            check_eq($sformatf("sweep_valid_%0d", c), {31'd0, bus.out_valid}, 32'd1);
            check_eq($sformatf("sweep_exec_%0d", c), {31'd0, bus.out_exec}, {31'd0, exp_vec[c]});
            check_eq($sformatf("sweep_tag_%0d", c), {27'd0, bus.out_tag}, 32'(c));
        end
        bus.in_valid = 1'b0;
        tick();
        check_eq("sweep_drain", {31'd0, bus.out_valid}, 32'd0);

        // Back-pressure with GE under N,V
        write_flags(4'b1001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_cond   = 4'hA;
        bus.in_tag    = 5'd3;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("bp_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
            check_eq($sformatf("bp_exec_%0d", i), {31'd0, bus.out_exec}, 32'd1);
            check_eq($sformatf("bp_tag_%0d", i), {27'd0, bus.out_tag}, 32'd3);
            check_eq($sformatf("bp_in_ready_%0d", i), {31'd0, bus.in_ready}, 32'd0);
            if (i < 3) tick();
        end
        write_flags(4'b1000);
        check_eq("bp_flags_q", {28'd0, bus.flags_q}, 32'h8);
        check_eq("bp_exec_after_we", {31'd0, bus.out_exec}, 32'd1);
        check_eq("bp_valid_after_we", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_exec", {31'd0, bus.out_exec}, 32'd1);
        tick();
        check_eq("bp_release_drain", {31'd0, bus.out_valid}, 32'd0);

        // Same-cycle flag write plus EQ request
        write_flags(4'b0000);
        bus.flags_we = 1'b1;
        bus.flags_in = 4'b0100;
        bus.in_valid = 1'b1;
        bus.in_cond  = 4'h0;
        bus.in_tag   = 5'd7;
        #1;
`ifdef FLAG_BYPASS_EN
        check_eq("same_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.flags_we = 1'b0;
        bus.in_valid = 1'b0;
`else
        check_eq("same_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.flags_we = 1'b0;
        check_eq("same_wait_valid", {31'd0, bus.out_valid}, 32'd0);
        #1;
        check_eq("same_retry_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
`endif
        check_eq("same_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("same_exec", {31'd0, bus.out_exec}, 32'd1);
        check_eq("same_tag", {27'd0, bus.out_tag}, 32'd7);
        tick();
        check_eq("same_drain", {31'd0, bus.out_valid}, 32'd0);

        // Flush with a held decision and a competing request
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_cond   = 4'hE;
        bus.in_tag    = 5'd9;
        tick();
        check_eq("flush_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("flush_pre_tag", {27'd0, bus.out_tag}, 32'd9);
        bus.in_tag    = 5'd10;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        bus.flags_we  = 1'b1;
        bus.flags_in  = 4'b0010;
        tick();
        bus.flush    = 1'b0;
        bus.flags_we = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("flush_flags_q", {28'd0, bus.flags_q}, 32'h2);
        tick();
        check_eq("flush_no_accept", {31'd0, bus.out_valid}, 32'd0);

        // AL/NV streaming, no bubbles
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_cond  = (i % 2 == 0) ? 4'hE : 4'hF;
            bus.in_tag   = 5'(i + 16);
            tick();
            check_eq($sformatf("stream_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
            check_eq($sformatf("stream_exec_%0d", i), {31'd0, bus.out_exec},
                     (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("stream_tag_%0d", i), {27'd0, bus.out_tag}, 32'(i + 16));
        end
        bus.in_valid = 1'b0;
        tick();
        check_eq("stream_drain", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while holding a decision
        write_flags(4'b1111);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_cond   = 4'hE;
        bus.in_tag    = 5'd21;
        tick();
        bus.in_valid = 1'b0;
        check_eq("arst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("arst_out_exec", {31'd0, bus.out_exec}, 32'd0);
        check_eq("arst_out_tag", {27'd0, bus.out_tag}, 32'd0);
        check_eq("arst_flags_q", {28'd0, bus.flags_q}, 32'd0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check_eq("arst_no_replay", {31'd0, bus.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
